// File: rtl/dmem_mmio_responder_if.sv
// dmem_mmio_responder_if
//  Bundles the processor data-memory port and the output-FIFO sink handshake
//  for the dmem_mmio_responder.
//  Signals:
//   address   word address from processor
//   data      write data from processor
//   wren      write enable
//   q         registered read data back to processor
//   out_data  FIFO head word
//   out_valid FIFO non-empty
//   out_ready sink accepts head word
//   overflow  sticky "a push was dropped" flag
//  Modports:
//   master  processor/sink side (drives address, data, wren, out_ready)
//   slave   responder side (drives q, out_data, out_valid, overflow)
interface dmem_mmio_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  overflow;

    modport master (
        output address, data, wren, out_ready,
        input  q, out_data, out_valid, overflow
    );

    modport slave (
        input  address, data, wren, out_ready,
        output q, out_data, out_valid, overflow
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//  Stands in for the processor's data-memory syncram during system-level test.
//  Provides a synchronous word RAM at the bottom of the address space and an
//  MMIO page at 0xF00..0xFFF containing a free-running cycle counter and an
//  output FIFO drained by a valid/ready sink.
//  Ports:
//   clock  single clock, all state changes on the rising edge
//   reset  asynchronous, active-high; clears q, counter, FIFO and overflow
//   bus    dmem_mmio_responder_if.slave (processor port + FIFO sink port)
//  Address map (word addresses):
//   0x000..RAM_WORDS-1  RAM
//   0xF00 CYCLE   R: counter          W: counter <= 0
//   0xF01 OUTQ    R: FIFO count       W: push data
//   0xF02 STATUS  R: {overflow, full, empty, 2'b0}  W: data[0]=1 clears overflow
//   anything else reads 0, writes ignored
module dmem_mmio_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_WORDS  = 3840,
    parameter int FIFO_DEPTH = 8
) (
    input logic                 clock,
    input logic                 reset,
    dmem_mmio_responder_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] CYCLE_ADDR  = ADDR_WIDTH'('hF00);
    localparam logic [ADDR_WIDTH-1:0] OUTQ_ADDR   = ADDR_WIDTH'('hF01);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'('hF02);
    localparam logic [CNT_W-1:0]      FULL_COUNT  = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] ram      [RAM_WORDS];
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] cycle_count;
    logic                  overflow_r;

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  in_ram;
    logic                  empty;
    logic                  full;
    logic                  push_req;
    logic                  pop;
    logic                  enq;
    logic                  drop;
    logic                  cycle_wr;
    logic                  clear_ovf;

    assign in_ram    = 32'(bus.address) < 32'(RAM_WORDS);
    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign push_req  = bus.wren && (bus.address == OUTQ_ADDR);
    assign pop       = !empty && bus.out_ready;
    // A push into a full FIFO still lands when the head leaves on the same
    // edge; the slot being written is exactly the one being vacated.
    assign enq       = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign cycle_wr  = bus.wren && (bus.address == CYCLE_ADDR);
    assign clear_ovf = bus.wren && (bus.address == STATUS_ADDR) && bus.data[0];

    // The head word is masked to zero while empty so that out_data reads 0
    // after reset even though the storage itself is never cleared.
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : fifo_mem[rd_ptr];
    assign bus.overflow  = overflow_r;

    // Read mux sees only pre-edge state, which gives old-data semantics on a
    // read-during-write and pre-push/pop values for the MMIO registers.
    always_comb begin
        rd_data = '0;
        if (in_ram) begin
            rd_data = ram[bus.address];
        end else begin
            case (bus.address)
                CYCLE_ADDR:  rd_data = cycle_count;
                OUTQ_ADDR:   rd_data = DATA_WIDTH'(count);
                STATUS_ADDR: rd_data = DATA_WIDTH'({overflow_r, full, empty, 2'b00});
                default:     rd_data = '0;
            endcase
        end
    end

    // RAM storage has no reset; its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (bus.wren && in_ram) begin
            ram[bus.address] <= bus.data;
        end
    end

    // FIFO storage likewise; validity is carried entirely by count.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= bus.data;
        end
    end

    // Control state: read register, cycle counter, FIFO pointers/count and
    // the sticky overflow flag. Reset aborts any push or pop in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.q       <= '0;
            cycle_count <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_r  <= 1'b0;
        end else begin
            bus.q <= rd_data;

            // A write to CYCLE beats the increment on the same edge.
            if (cycle_wr) begin
                cycle_count <= '0;
            end else begin
                cycle_count <= cycle_count + DATA_WIDTH'(1);
            end

            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({enq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Setting has priority over a clear arriving on the same edge.
            if (drop) begin
                overflow_r <= 1'b1;
            end else if (clear_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

endmodule
